// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e   : sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   port_e    : requester ids (CPU load/store unit, loader/debug port)
//   AlignMask : byte-offset bits that must be zero for a word access
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef enum logic {
    PortCpu = 1'b0,
    PortLdr = 1'b1
  } port_e;

  localparam logic [31:0] AlignMask = 32'h0000_0003;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
//   p0_* / p1_* : request side (req, we, addr, wdata in; ack, rdata, err out)
//   mem_*       : RAM side (address, wdata, write_en, read_en out; rdata in)
// Modports: slave = arbiter view, master = environment (requesters + RAM) view.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  p0_req;
  logic                  p0_we;
  logic [31:0]           p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_ack;
  logic [DATA_WIDTH-1:0] p0_rdata;
  logic                  p0_err;

  logic                  p1_req;
  logic                  p1_we;
  logic [31:0]           p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_ack;
  logic [DATA_WIDTH-1:0] p1_rdata;
  logic                  p1_err;

  logic [31:0]           mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_write_en;
  logic                  mem_read_en;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata, p1_err,
    output mem_address, mem_wdata, mem_write_en, mem_read_en,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata, p1_err,
    input  mem_address, mem_wdata, mem_write_en, mem_read_en,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way grant.
//   req_i        : {req1, req0}
//   last_grant_i : port granted most recently
//   valid_o      : at least one request present
//   grant_o      : winning port (meaningful only when valid_o)
// On a tie, FIXED_PRIO=1 always picks port 0; otherwise the port that did not win last time.
module rr_arb2
  import dmem_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req_i,
  input  port_e      last_grant_i,
  output logic       valid_o,
  output port_e      grant_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = PortCpu;
    unique case (req_i)
      2'b01:   grant_o = PortCpu;
      2'b10:   grant_o = PortLdr;
      2'b11: begin
        if (FIXED_PRIO) begin
          grant_o = PortCpu;
        end else begin
          grant_o = (last_grant_i == PortCpu) ? PortLdr : PortCpu;
        end
      end
      default: grant_o = PortCpu;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequences two requesters onto a single-port data RAM.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : request ports p0 (CPU) / p1 (loader) and the RAM drive (see dmem_arbiter_if)
//   busy  : high whenever the sequencer is not idle
// Each transaction takes IDLE -> ACCESS (one RAM cycle) -> RESP (one-cycle ack), so a request
// seen in IDLE cycle N hits the RAM in N+1 and is acknowledged in N+2.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output logic           busy
);

  localparam logic [31:0] AddrLimit = 32'(DEPTH * 4);

  state_e                state_q, state_d;
  port_e                 last_grant_q, last_grant_d;
  port_e                 port_q, port_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [31:0]           mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_write_en_q, mem_write_en_d;
  logic                  mem_read_en_q, mem_read_en_d;

  logic                  grant_valid;
  port_e                 grant_id;
  logic                  win_we;
  logic [31:0]           win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  win_err;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_rr_arb2 (
    .req_i       ({bus.p1_req, bus.p0_req}),
    .last_grant_i(last_grant_q),
    .valid_o     (grant_valid),
    .grant_o     (grant_id)
  );

  // Fields of the winning requester, only meaningful in IDLE.
  always_comb begin
    if (grant_id == PortLdr) begin
      win_we    = bus.p1_we;
      win_addr  = bus.p1_addr;
      win_wdata = bus.p1_wdata;
    end else begin
      win_we    = bus.p0_we;
      win_addr  = bus.p0_addr;
      win_wdata = bus.p0_wdata;
    end
    win_err = (|(win_addr & AlignMask)) | (win_addr >= AddrLimit);
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    port_d         = port_q;
    we_d           = we_q;
    err_d          = err_q;
    rdata_d        = rdata_q;
    // RAM strobes default low so they last exactly the ACCESS cycle.
    mem_address_d  = '0;
    mem_wdata_d    = '0;
    mem_write_en_d = 1'b0;
    mem_read_en_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d      = StAccess;
          port_d       = grant_id;
          last_grant_d = grant_id;
          we_d         = win_we;
          err_d        = win_err;
          if (!win_err) begin
            mem_address_d  = win_addr;
            mem_wdata_d    = win_wdata;
            mem_write_en_d = win_we;
            mem_read_en_d  = !win_we;
          end
        end
      end
      StAccess: begin
        state_d = StResp;
        rdata_d = (!we_q && !err_q) ? bus.mem_rdata : '0;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      last_grant_q   <= PortLdr;
      port_q         <= PortCpu;
      we_q           <= 1'b0;
      err_q          <= 1'b0;
      rdata_q        <= '0;
      mem_address_q  <= '0;
      mem_wdata_q    <= '0;
      mem_write_en_q <= 1'b0;
      mem_read_en_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      port_q         <= port_d;
      we_q           <= we_d;
      err_q          <= err_d;
      rdata_q        <= rdata_d;
      mem_address_q  <= mem_address_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_write_en_q <= mem_write_en_d;
      mem_read_en_q  <= mem_read_en_d;
    end
  end

  logic resp_p0;
  logic resp_p1;

  always_comb begin
    resp_p0          = (state_q == StResp) && (port_q == PortCpu);
    resp_p1          = (state_q == StResp) && (port_q == PortLdr);
    bus.p0_ack       = resp_p0;
    bus.p0_err       = resp_p0 & err_q;
    bus.p0_rdata     = resp_p0 ? rdata_q : '0;
    bus.p1_ack       = resp_p1;
    bus.p1_err       = resp_p1 & err_q;
    bus.p1_rdata     = resp_p1 ? rdata_q : '0;
    bus.mem_address  = mem_address_q;
    bus.mem_wdata    = mem_wdata_q;
    bus.mem_write_en = mem_write_en_q;
    bus.mem_read_en  = mem_read_en_q;
    busy             = (state_q != StIdle);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance with a RAM model, plus a
// fixed-priority instance used for the tie-break ordering steps.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy_rr;
  logic busy_fp;

  int n_pass  = 0;
  int n_total = 0;
  int wr_cnt  = 0;
  int rd_cnt  = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(32)) bus_rr ();
  dmem_arbiter_if #(.DATA_WIDTH(32)) bus_fp ();

  dmem_arbiter #(
    .DEPTH     (32),
    .DATA_WIDTH(32),
    .FIXED_PRIO(1'b0)
  ) u_dut_rr (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_rr),
    .busy (busy_rr)
  );

  dmem_arbiter #(
    .DEPTH     (32),
    .DATA_WIDTH(32),
    .FIXED_PRIO(1'b1)
  ) u_dut_fp (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_fp),
    .busy (busy_fp)
  );

  // RAM models: combinational read, posedge write.
  logic [31:0] ram_rr [32];
  logic [31:0] ram_fp [32];

  assign bus_rr.mem_rdata = ram_rr[bus_rr.mem_address[6:2]];
  assign bus_fp.mem_rdata = ram_fp[bus_fp.mem_address[6:2]];

  always @(posedge clk) begin
    if (bus_rr.mem_write_en) ram_rr[bus_rr.mem_address[6:2]] <= bus_rr.mem_wdata;
    if (bus_fp.mem_write_en) ram_fp[bus_fp.mem_address[6:2]] <= bus_fp.mem_wdata;
    if (bus_rr.mem_write_en) wr_cnt <= wr_cnt + 1;
    if (bus_rr.mem_read_en) rd_cnt <= rd_cnt + 1;
    if ((bus_rr.mem_write_en && bus_rr.mem_read_en) ||
        (bus_fp.mem_write_en && bus_fp.mem_read_en)) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the round-robin instance, starting in IDLE.
  task automatic do_txn(input string tag, input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit exp_err,
                        input logic [31:0] exp_rdata);
    if (port) begin
      bus_rr.p1_we = we; bus_rr.p1_addr = addr; bus_rr.p1_wdata = wdata; bus_rr.p1_req = 1'b1;
    end else begin
      bus_rr.p0_we = we; bus_rr.p0_addr = addr; bus_rr.p0_wdata = wdata; bus_rr.p0_req = 1'b1;
    end
    tick();
    check({tag, ".mem_we"}, bus_rr.mem_write_en, we & !exp_err);
    check({tag, ".mem_re"}, bus_rr.mem_read_en, !we & !exp_err);
    check({tag, ".mem_addr"}, bus_rr.mem_address, exp_err ? 32'h0 : addr);
    tick();
    check({tag, ".ack"}, port ? bus_rr.p1_ack : bus_rr.p0_ack, 1'b1);
    check({tag, ".other_ack"}, port ? bus_rr.p0_ack : bus_rr.p1_ack, 1'b0);
    check({tag, ".err"}, port ? bus_rr.p1_err : bus_rr.p0_err, exp_err);
    check({tag, ".rdata"}, port ? bus_rr.p1_rdata : bus_rr.p0_rdata, exp_rdata);
    bus_rr.p0_req = 1'b0;
    bus_rr.p1_req = 1'b0;
    tick();
    check({tag, ".idle"}, busy_rr, 1'b0);
  endtask

  initial begin
    int wr_before;
    int rd_before;
    bit exp_p1;
    for (int i = 0; i < 32; i++) begin
      ram_rr[i] = 32'h0;
      ram_fp[i] = 32'h0;
    end
    bus_rr.p0_req = 1'b0; bus_rr.p0_we = 1'b0; bus_rr.p0_addr = '0; bus_rr.p0_wdata = '0;
    bus_rr.p1_req = 1'b0; bus_rr.p1_we = 1'b0; bus_rr.p1_addr = '0; bus_rr.p1_wdata = '0;
    bus_fp.p0_req = 1'b0; bus_fp.p0_we = 1'b0; bus_fp.p0_addr = '0; bus_fp.p0_wdata = '0;
    bus_fp.p1_req = 1'b0; bus_fp.p1_we = 1'b0; bus_fp.p1_addr = '0; bus_fp.p1_wdata = '0;

    // 1: requests during reset are ignored.
    #1;
    bus_rr.p0_req = 1'b1; bus_rr.p0_we = 1'b1; bus_rr.p0_addr = 32'h4;
    bus_rr.p1_req = 1'b1; bus_rr.p1_we = 1'b1; bus_rr.p1_addr = 32'h8;
    repeat (3) tick();
    check("rst.busy", busy_rr, 1'b0);
    check("rst.p0_ack", bus_rr.p0_ack, 1'b0);
    check("rst.p1_ack", bus_rr.p1_ack, 1'b0);
    check("rst.p0_rdata", bus_rr.p0_rdata, 32'h0);
    check("rst.mem_we", bus_rr.mem_write_en, 1'b0);
    check("rst.mem_re", bus_rr.mem_read_en, 1'b0);
    check("rst.mem_addr", bus_rr.mem_address, 32'h0);
    check("rst.wr_cnt", wr_cnt, 0);
    bus_rr.p0_req = 1'b0; bus_rr.p1_req = 1'b0;
    reset = 1'b1;
    tick();

    // 3: held tie -> RR alternates starting with P0; fixed priority always P0.
    bus_rr.p0_we = 1'b0; bus_rr.p0_addr = 32'h10; bus_rr.p0_req = 1'b1;
    bus_rr.p1_we = 1'b0; bus_rr.p1_addr = 32'h14; bus_rr.p1_req = 1'b1;
    bus_fp.p0_we = 1'b0; bus_fp.p0_addr = 32'h10; bus_fp.p0_req = 1'b1;
    bus_fp.p1_we = 1'b0; bus_fp.p1_addr = 32'h14; bus_fp.p1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_p1 = (k % 2) == 1;
      tick();
      tick();
      check($sformatf("rr%0d.p0_ack", k), bus_rr.p0_ack, !exp_p1);
      check($sformatf("rr%0d.p1_ack", k), bus_rr.p1_ack, exp_p1);
      check($sformatf("fp%0d.p0_ack", k), bus_fp.p0_ack, 1'b1);
      check($sformatf("fp%0d.p1_ack", k), bus_fp.p1_ack, 1'b0);
      tick();
    end
    bus_rr.p0_req = 1'b0; bus_rr.p1_req = 1'b0;
    bus_fp.p0_req = 1'b0;
    tick();
    tick();
    check("fp.p1_served", bus_fp.p1_ack, 1'b1);
    check("fp.p0_quiet", bus_fp.p0_ack, 1'b0);
    bus_fp.p1_req = 1'b0;
    tick();

    // 2: P0 write then read back.
    do_txn("p0wr", 1'b0, 1'b1, 32'h8, 32'h0000_ABCD, 1'b0, 32'h0);
    do_txn("p0rd", 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0000_ABCD);
    // Loader preload at the last valid word.
    do_txn("p1wr_top", 1'b1, 1'b1, 32'h7C, 32'h1234_5678, 1'b0, 32'h0);
    do_txn("p1rd_top", 1'b1, 1'b0, 32'h7C, 32'h0, 1'b0, 32'h1234_5678);

    // 4: out-of-range and misaligned accesses never touch the RAM.
    wr_before = wr_cnt;
    rd_before = rd_cnt;
    do_txn("p1wr_oor", 1'b1, 1'b1, 32'h80, 32'hFFFF_FFFF, 1'b1, 32'h0);
    do_txn("p1rd_mis", 1'b1, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0);
    check("err.wr_cnt", wr_cnt, wr_before);
    check("err.rd_cnt", rd_cnt, rd_before);

    // 5: reset during the ACCESS cycle of a write.
    bus_rr.p0_we = 1'b1; bus_rr.p0_addr = 32'hC; bus_rr.p0_wdata = 32'h55AA; bus_rr.p0_req = 1'b1;
    tick();
    check("mid.mem_we_pre", bus_rr.mem_write_en, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("mid.mem_we", bus_rr.mem_write_en, 1'b0);
    check("mid.busy", busy_rr, 1'b0);
    check("mid.p0_ack", bus_rr.p0_ack, 1'b0);
    bus_rr.p0_req = 1'b0;
    tick();
    check("mid.no_ack", bus_rr.p0_ack, 1'b0);
    reset = 1'b1;
    tick();
    do_txn("post_rst", 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0000_ABCD);

    // 6: req held one cycle past ack starts a second transaction.
    bus_rr.p1_we = 1'b0; bus_rr.p1_addr = 32'h8; bus_rr.p1_req = 1'b1;
    tick();
    tick();
    check("hold.ack1", bus_rr.p1_ack, 1'b1);
    tick();
    check("hold.idle_ack", bus_rr.p1_ack, 1'b0);
    check("hold.idle_busy", busy_rr, 1'b0);
    tick();
    check("hold.access2", bus_rr.mem_read_en, 1'b1);
    bus_rr.p1_req = 1'b0;
    tick();
    check("hold.ack2", bus_rr.p1_ack, 1'b1);
    check("hold.rdata2", bus_rr.p1_rdata, 32'h0000_ABCD);
    tick();
    tick();
    check("hold.no_third", busy_rr, 1'b0);

    check("never_both_en", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
